// File: rtl/score_pkg.sv
// Shared PS/2 constants, default key codes and decoder state encoding
// for the score tracking stage.
package score_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] KEY_INC_DEF = 8'h29;
  localparam logic [7:0] KEY_DEC_DEF = 8'h66;
  localparam logic [7:0] KEY_CLR_DEF = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_e;

endpackage

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: prefix FSM plus per-key held flags that
// turn make codes into single-cycle events with typematic suppression.
import score_pkg::*;

module ps2_key_decoder #(
  parameter logic [7:0] KEY_INC = KEY_INC_DEF,
  parameter logic [7:0] KEY_DEC = KEY_DEC_DEF,
  parameter logic [7:0] KEY_CLR = KEY_CLR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ev_inc,
  output logic       o_ev_dec,
  output logic       o_ev_clr
);

  dec_state_e r_state;
  dec_state_e w_state_nxt;
  logic [2:0] r_held;
  logic [2:0] w_held_nxt;
  logic [2:0] w_hit;
  logic [2:0] w_ev;

  assign w_hit = {i_data == KEY_CLR,
                  i_data == KEY_DEC,
                  i_data == KEY_INC};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_held  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_held  <= w_held_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    w_ev        = '0;
    if (i_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          unique case (1'b1)
            (i_data == PS2_EXT): w_state_nxt = ST_EXT;
            (i_data == PS2_BRK): w_state_nxt = ST_BRK;
            default: begin
              // a held key repeats its make code; only the first counts
              w_ev       = w_hit & ~r_held;
              w_held_nxt = r_held | w_hit;
            end
          endcase
        end
        ST_EXT: begin
          w_state_nxt = (i_data == PS2_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_BRK: begin
          w_held_nxt  = r_held & ~w_hit;
          w_state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign o_ev_inc = w_ev[0];
  assign o_ev_dec = w_ev[1];
  assign o_ev_clr = w_ev[2];

endmodule

// File: rtl/score_tracker.sv
// Accumulates key events per frame and commits them to a saturating
// score at each frame boundary so the display never changes mid-frame.
import score_pkg::*;

module score_tracker #(
  parameter int         MAX_SCORE = 12,
  parameter logic [7:0] KEY_INC   = KEY_INC_DEF,
  parameter logic [7:0] KEY_DEC   = KEY_DEC_DEF,
  parameter logic [7:0] KEY_CLR   = KEY_CLR_DEF,
  parameter int         PEND_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        screenEnd,
  output logic [31:0] score,
  output logic        score_update
);

  localparam int SW = $clog2(MAX_SCORE + 1);
  localparam int ACC_W = (SW + 2 > 6) ? PEND_W + SW + 2 : PEND_W + 6;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'(MAX_SCORE);

  logic              w_ev_inc;
  logic              w_ev_dec;
  logic              w_ev_clr;
  logic [PEND_W-1:0] r_pend_inc;
  logic [PEND_W-1:0] r_pend_dec;
  logic              r_pend_clr;
  logic [PEND_W-1:0] w_inc_base;
  logic [PEND_W-1:0] w_dec_base;
  logic              w_clr_base;
  logic [PEND_W-1:0] w_inc_nxt;
  logic [PEND_W-1:0] w_dec_nxt;
  logic              w_clr_nxt;
  logic [SW-1:0]     r_score;
  logic              r_upd;
  logic [SW-1:0]     w_base;
  logic signed [ACC_W-1:0] w_sum;
  logic [SW-1:0]     w_new;

  ps2_key_decoder #(
    .KEY_INC (KEY_INC),
    .KEY_DEC (KEY_DEC),
    .KEY_CLR (KEY_CLR)
  ) u_dec (
    .clk      (clk),
    .reset    (reset),
    .i_data   (rx_data),
    .i_valid  (rx_valid),
    .o_ev_inc (w_ev_inc),
    .o_ev_dec (w_ev_dec),
    .o_ev_clr (w_ev_clr)
  );

  // an event in the commit cycle lands in the freshly cleared state
  assign w_inc_base = screenEnd ? '0 : r_pend_inc;
  assign w_dec_base = screenEnd ? '0 : r_pend_dec;
  assign w_clr_base = screenEnd ? 1'b0 : r_pend_clr;

  always_comb begin
    w_inc_nxt = w_inc_base;
    w_dec_nxt = w_dec_base;
    w_clr_nxt = w_clr_base;
    unique case (1'b1)
      w_ev_clr: begin
        w_clr_nxt = 1'b1;
        w_inc_nxt = '0;
        w_dec_nxt = '0;
      end
      w_ev_inc: begin
        if (w_inc_base != PEND_MAX) w_inc_nxt = w_inc_base + 1'b1;
      end
      w_ev_dec: begin
        if (w_dec_base != PEND_MAX) w_dec_nxt = w_dec_base + 1'b1;
      end
      default: ;
    endcase
  end

  assign w_base = r_pend_clr ? '0 : r_score;
  assign w_sum  = ACC_W'(w_base) + ACC_W'(r_pend_inc)
                - ACC_W'(r_pend_dec);

  always_comb begin
    w_new = SW'(w_sum);
    if (w_sum[ACC_W-1])      w_new = '0;
    else if (w_sum > SUM_MAX) w_new = SW'(MAX_SCORE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend_inc <= '0;
      r_pend_dec <= '0;
      r_pend_clr <= 1'b0;
      r_score    <= '0;
      r_upd      <= 1'b0;
    end else begin
      r_pend_inc <= w_inc_nxt;
      r_pend_dec <= w_dec_nxt;
      r_pend_clr <= w_clr_nxt;
      if (screenEnd) r_score <= w_new;
      r_upd <= screenEnd && (w_new != r_score);
    end
  end

  assign score        = {{(32 - SW){1'b0}}, r_score};
  assign score_update = r_upd;

endmodule
